// File: rtl/lift_seq_53_pkg.sv
// Shared constants and types for the 5/3 lifting sequencer and its ALU.
package lift_pkg;
    localparam int W     = 26;
    localparam int AW    = 7;
    localparam int ROUND = 2;

    typedef enum logic [2:0] {IDLE, S1_PRIME, S1_RUN, S2_PRIME, S2_RUN, FIN} state_e;
    typedef enum logic {PREDICT, UPDATE} stage_e;

    // Forward runs predict first; inverse runs undo-update first.
    function automatic stage_e stage_of(input state_e st, input logic fwd);
        logic first;
        first = (st == S1_PRIME) || (st == S1_RUN);
        return (first == fwd) ? PREDICT : UPDATE;
    endfunction
endpackage

// File: rtl/lift_alu_53.sv
// Lifting step shared by predict and update: y = x -/+ ((a + b [+ ROUND]) >>> k).
module lift_alu_53
    import lift_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] x,
    input  stage_e       stage,
    input  logic         fwd,
    output logic [W-1:0] y
);
    // Two guard bits keep a + b + ROUND exact even at the positive extreme.
    logic signed [W+1:0] sum;
    logic signed [W-1:0] delta;

    always_comb begin
        sum = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        if (stage == PREDICT) delta = W'(sum >>> 1);
        else                  delta = W'((sum + (W+2)'(ROUND)) >>> 2);
        // Forward predict and inverse update subtract; the other two add.
        if ((stage == PREDICT) == fwd) y = x - delta;
        else                           y = x + delta;
    end
endmodule

// File: rtl/lift_seq_53.sv
// In-place 5/3 lifting sequencer: two stages over the even/odd RAM banks,
// two priming cycles per stage then three cycles per sample.
module lift_seq_53
    import lift_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fwd,
    input  logic [AW:0]   n_pairs,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pix_addr_even,
    output logic [W-1:0]  pix_din_even,
    output logic          pix_we_even,
    input  logic [W-1:0]  pix_dout_even,
    output logic [AW-1:0] pix_addr_odd,
    output logic [W-1:0]  pix_din_odd,
    output logic          pix_we_odd,
    input  logic [W-1:0]  pix_dout_odd
);
    state_e        state_q, state_n;
    stage_e        stage_q, stage_n;
    logic [1:0]    phase_q, phase_n;
    logic [AW:0]   idx_q, idx_n, idx_inc, n_q, n_last;
    logic          fwd_q, last, prime_q, run_q, run_n;
    logic [W-1:0]  e_prev, o_prev, alu_a, alu_b, alu_x, alu_y;
    logic [AW-1:0] addr_even_n, addr_odd_n;
    logic          we_even_n, we_odd_n;

    assign stage_q = stage_of(state_q, fwd_q);
    assign stage_n = stage_of(state_n, fwd_q);
    assign prime_q = (state_q == S1_PRIME) || (state_q == S2_PRIME);
    assign run_q   = (state_q == S1_RUN)   || (state_q == S2_RUN);
    assign run_n   = (state_n == S1_RUN)   || (state_n == S2_RUN);
    assign n_last  = n_q - (AW+1)'(1);
    assign last    = (idx_q == n_last);
    assign busy    = (state_q != IDLE) && (state_q != FIN);
    assign done    = (state_q == FIN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            idx_q   <= idx_n;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        idx_n   = idx_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_n = S1_PRIME;
                phase_n = '0;
                idx_n   = '0;
            end
            S1_PRIME, S2_PRIME: begin
                if (n_q == '0) state_n = FIN;
                else if (phase_q == 2'd1) begin
                    state_n = (state_q == S1_PRIME) ? S1_RUN : S2_RUN;
                    phase_n = '0;
                end else phase_n = 2'd1;
            end
            S1_RUN, S2_RUN: begin
                if (phase_q != 2'd2) phase_n = phase_q + 2'd1;
                else begin
                    phase_n = '0;
                    if (last) begin
                        idx_n   = '0;
                        state_n = (state_q == S1_RUN) ? S2_PRIME : FIN;
                    end else idx_n = idx_q + (AW+1)'(1);
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Port values for the next cycle; even reads clamp at N-1 for the right extension.
    always_comb begin
        idx_inc     = idx_n + (AW+1)'(1);
        addr_even_n = '0;
        addr_odd_n  = '0;
        if (run_n) begin
            addr_odd_n = idx_n[AW-1:0];
            if (stage_n == UPDATE)  addr_even_n = idx_n[AW-1:0];
            else if (idx_inc < n_q) addr_even_n = idx_inc[AW-1:0];
            else                    addr_even_n = n_last[AW-1:0];
        end
        we_even_n = run_n && (phase_n == 2'd2) && (stage_n == UPDATE);
        we_odd_n  = run_n && (phase_n == 2'd2) && (stage_n == PREDICT);
    end

    always_comb begin
        alu_a = (stage_q == PREDICT) ? e_prev        : o_prev;
        alu_b = (stage_q == PREDICT) ? pix_dout_even : pix_dout_odd;
        alu_x = (stage_q == PREDICT) ? pix_dout_odd  : pix_dout_even;
    end

    lift_alu_53 u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .x     (alu_x),
        .stage (stage_q),
        .fwd   (fwd_q),
        .y     (alu_y)
    );

    // NOTE: the neighbour registers are reset too; they are tiny and keep the datapath free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q         <= 1'b0;
            n_q           <= '0;
            e_prev        <= '0;
            o_prev        <= '0;
            pix_addr_even <= '0;
            pix_addr_odd  <= '0;
            pix_din_even  <= '0;
            pix_din_odd   <= '0;
            pix_we_even   <= 1'b0;
            pix_we_odd    <= 1'b0;
        end else begin
            pix_addr_even <= addr_even_n;
            pix_addr_odd  <= addr_odd_n;
            pix_we_even   <= we_even_n;
            pix_we_odd    <= we_odd_n;
            if (state_q == IDLE && start) begin
                fwd_q <= fwd;
                n_q   <= n_pairs;
            end
            // Read data is valid in phase 1 of both prime and run.
            if ((prime_q || run_q) && phase_q == 2'd1) begin
                if (stage_q == PREDICT) e_prev <= pix_dout_even;
                else                    o_prev <= pix_dout_odd;
            end
            if (run_q && phase_q == 2'd1) begin
                if (stage_q == PREDICT) pix_din_odd  <= alu_y;
                else                    pix_din_even <= alu_y;
            end
        end
    end
endmodule
